deserializer_align: RTL

Receive-side counterpart of the 60:1 serializer. Samples the 1-bit serial stream at clk_25G and shifts it into a 60-bit window, LSB first: the first bit received of a word lands in bit 0. An alignment FSM finds the word boundary by matching a training sync word. Once locked, it emits aligned 60-bit parallel words with a one-cycle valid strobe to the descrambler.

---
 rtl/deserializer_align_if.sv | 10 +
 rtl/deserializer_align.sv | 68 ++++++
 2 files changed

// File: rtl/deserializer_align_if.sv
// deserializer_align_if: serial input, realign pulse and aligned word outputs of the deserializer
interface deserializer_align_if #(parameter int WIDTH = 60);
  logic             data_serial;
  logic             realign;
  logic [WIDTH-1:0] data_parallel;
  logic             data_valid;
  logic             locked;
  modport master (output data_serial, output realign, input data_parallel, input data_valid, input locked);
  modport slave (input data_serial, input realign, output data_parallel, output data_valid, output locked);
endinterface

// File: rtl/deserializer_align.sv
// deserializer_align: LSB-first serial-to-parallel converter with sync-word boundary alignment
module deserializer_align #(
  parameter int               WIDTH     = 60,
  parameter logic [WIDTH-1:0] SYNC_WORD = 60'hA5C396E1F0781E4,
  parameter int               LOCK_CNT  = 4
) (
  input logic                 clk_25G,
  input logic                 rst_n,
  deserializer_align_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:1] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [WIDTH-1:0] data_parallel_q, data_parallel_d;
  logic             data_valid_q, data_valid_d;
  logic             locked_q, locked_d;
  logic [WIDTH-1:0] nxt;
  logic             is_sync, boundary, strobe;
  logic [3:0]       match_inc;
  always_ff @(posedge clk_25G) begin
    if (!rst_n) begin
      state_q         <= HUNT;
      shreg_q         <= '0;
      bit_cnt_q       <= '0;
      match_cnt_q     <= '0;
      data_parallel_q <= '0;
      data_valid_q    <= 1'b0;
      locked_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      bit_cnt_q       <= bit_cnt_d;
      match_cnt_q     <= match_cnt_d;
      data_parallel_q <= data_parallel_d;
      data_valid_q    <= data_valid_d;
      locked_q        <= locked_d;
    end
  end
  always_comb begin
    nxt       = {bus.data_serial, shreg_q};
    is_sync   = nxt == SYNC_WORD;
    boundary  = bit_cnt_q == CW'(WIDTH - 1);
    match_inc = match_cnt_q + 4'd1;
    state_d   = bus.realign ? HUNT
              : (state_q == HUNT) ? (is_sync ? ((LOCK_CNT == 1) ? LOCKED : CHECK) : HUNT)
              : (state_q == CHECK && boundary) ? (!is_sync ? HUNT : (match_inc == LOCK_N) ? LOCKED : CHECK)
              : state_q;
  end
  always_comb begin
    strobe          = !bus.realign && state_q == LOCKED && boundary;
    shreg_d         = nxt[WIDTH-1:1];
    bit_cnt_d       = (state_q == HUNT || boundary) ? '0 : bit_cnt_q + 1'b1;
    match_cnt_d     = bus.realign ? 4'd0
                    : (state_q == HUNT) ? (is_sync ? 4'd1 : 4'd0)
                    : (state_q == CHECK && boundary) ? (is_sync ? match_inc : 4'd0)
                    : match_cnt_q;
    data_parallel_d = strobe ? nxt : data_parallel_q;
    data_valid_d    = strobe;
    locked_d        = state_d == LOCKED;
  end
  assign bus.data_parallel = data_parallel_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.locked        = locked_q;
endmodule
